// File: rtl/matvec_pkg.sv
// Shared definitions for the streaming 8x8 signed matrix-vector multiplier.
// Holds the fixed dimensions, the control state encoding and the signed
// word types used on the input (matrix/vector elements) and output (y) sides.
package matvec_pkg;

  localparam int K  = 8;   // matrix dimension (fixed)
  localparam int IW = 14;  // input word width, signed
  localparam int OW = 28;  // output word width, signed

  typedef enum logic [1:0] {
    START  = 2'd0,
    LOAD_W = 2'd1,
    LOAD_X = 2'd2,
    OUT    = 2'd3
  } state_t;

  typedef logic signed [IW-1:0] in_word_t;
  typedef logic signed [OW-1:0] out_word_t;

endpackage

// File: rtl/dot8.sv
// Combinational 8-element signed dot product.
// Ports:
//   w_i : one matrix row, 8 signed IW-bit elements
//   x_i : vector, 8 signed IW-bit elements
//   y_o : sum of w_i[c]*x_i[c], OW bits, two's-complement wrap on overflow
module dot8
  import matvec_pkg::*;
(
  input  in_word_t  w_i [K],
  input  in_word_t  x_i [K],
  output out_word_t y_o
);

  out_word_t prod_s [K];
  out_word_t sum4_s [4];
  out_word_t sum2_s [2];

  // Full-precision products, then a balanced adder tree truncated to OW bits.
  // Operands are sign-extended to OW first so each product is the exact
  // 14x14 result (it always fits in 28 signed bits).
  always_comb begin
    for (int c = 0; c < K; c++) begin
      prod_s[c] = out_word_t'(w_i[c]) * out_word_t'(x_i[c]);
    end
    for (int i = 0; i < 4; i++) begin
      sum4_s[i] = prod_s[2*i] + prod_s[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      sum2_s[i] = sum4_s[2*i] + sum4_s[2*i+1];
    end
    y_o = sum2_s[0] + sum2_s[1];
  end

endmodule

// File: rtl/matvec8_stream.sv
// Streaming 8x8 signed matrix-vector multiplier, y = W*x.
// Words arrive one per input handshake: an optional 64-word matrix load
// (row-major) followed by the 8-word vector. The 8 results then leave one per
// output handshake. W persists across products until a new load.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   input_valid/ready/data, new_matrix : word-serial producer side
//   output_valid/ready/data            : word-serial consumer side
module matvec8_stream
  import matvec_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           input_valid,
  output logic           input_ready,
  input  logic [IW-1:0]  input_data,
  input  logic           new_matrix,
  output logic           output_valid,
  input  logic           output_ready,
  output logic [OW-1:0]  output_data
);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] row_q, row_d;
  in_word_t   w_q [K*K];
  in_word_t   x_q [K];

  logic       in_fire_s, out_fire_s;
  logic       w_we_s, x_we_s;
  logic [5:0] w_idx_s;
  logic [2:0] x_idx_s;
  in_word_t   w_row_s [K];
  out_word_t  dot_y_s;

  // Input is refused during reset and while results are being presented.
  assign input_ready  = ~reset & (state_q != OUT);
  assign output_valid = (state_q == OUT);
  assign in_fire_s    = input_valid & input_ready;
  assign out_fire_s   = output_valid & output_ready;

  // Next-state, counters and storage write strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    w_we_s  = 1'b0;
    x_we_s  = 1'b0;
    w_idx_s = cnt_q;
    x_idx_s = cnt_q[2:0];
    case (state_q)
      START: begin
        if (in_fire_s) begin
          cnt_d = 6'd1;
          if (new_matrix) begin
            w_we_s  = 1'b1;
            w_idx_s = 6'd0;
            state_d = LOAD_W;
          end else begin
            x_we_s  = 1'b1;
            x_idx_s = 3'd0;
            state_d = LOAD_X;
          end
        end else begin
          state_d = START;
        end
      end
      LOAD_W: begin
        if (in_fire_s) begin
          w_we_s = 1'b1;
          if (cnt_q == 6'd63) begin
            cnt_d   = 6'd0;
            state_d = LOAD_X;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          state_d = LOAD_W;
        end
      end
      LOAD_X: begin
        if (in_fire_s) begin
          x_we_s = 1'b1;
          if (cnt_q == 6'd7) begin
            cnt_d   = 6'd0;
            row_d   = 3'd0;
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          state_d = LOAD_X;
        end
      end
      OUT: begin
        if (out_fire_s) begin
          if (row_q == 3'd7) begin
            row_d   = 3'd0;
            state_d = START;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = START;
        cnt_d   = 6'd0;
        row_d   = 3'd0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= START;
      cnt_q   <= 6'd0;
      row_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Matrix and vector storage; W is only written during a matrix load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K*K; i++) w_q[i] <= '0;
      for (int i = 0; i < K; i++)   x_q[i] <= '0;
    end else begin
      if (w_we_s) w_q[w_idx_s] <= in_word_t'(input_data);
      if (x_we_s) x_q[x_idx_s] <= in_word_t'(input_data);
    end
  end

  // Select the current output row of W for the shared dot-product unit.
  always_comb begin
    for (int c = 0; c < K; c++) begin
      w_row_s[c] = w_q[{row_q, 3'(c)}];
    end
  end

  dot8 u_dot8 (
    .w_i (w_row_s),
    .x_i (x_q),
    .y_o (dot_y_s)
  );

  assign output_data = dot_y_s;

endmodule

// File: tb/tb_matvec8_stream.sv
// Directed and randomized self-checking bench for matvec8_stream.
module tb_matvec8_stream;
  import matvec_pkg::*;

  logic          clk;
  logic          reset;
  logic          input_valid;
  logic          input_ready;
  logic [IW-1:0] input_data;
  logic          new_matrix;
  logic          output_valid;
  logic          output_ready;
  logic [OW-1:0] output_data;

  int total;
  int bad;

  in_word_t  wv [64];
  in_word_t  xv [8];
  out_word_t ev [8];

  matvec8_stream dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .new_matrix   (new_matrix),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word after an optional idle gap and hold it until accepted.
  task automatic send(input in_word_t d, input logic nm, input int gap);
    int g;
    g = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    input_valid = 1'b1;
    input_data  = d;
    new_matrix  = nm;
    while (!input_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      total++; bad++;
      $display("FAIL send_timeout: input_ready stayed %b, required 1", input_ready);
    end
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    input_data  = 'x;
    new_matrix  = 1'bx;
  endtask

  // Send an optional matrix (wv) then the vector (xv).
  task automatic load_product(input logic nm, input int gap_max);
    if (nm) begin
      for (int i = 0; i < 64; i++) send(wv[i], 1'b1, $urandom_range(0, gap_max));
    end
    for (int i = 0; i < 8; i++) send(xv[i], nm, $urandom_range(0, gap_max));
  endtask

  // Take one result with output_ready held high.
  task automatic recv(output out_word_t d);
    int g;
    g = 0;
    @(negedge clk);
    output_ready = 1'b1;
    while (!output_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      total++; bad++;
      $display("FAIL recv_timeout: output_valid stayed %b, required 1", output_valid);
    end
    d = output_data;
    @(posedge clk);
    #1;
    output_ready = 1'b0;
  endtask

  function automatic out_word_t model_row(int r);
    longint s;
    s = 0;
    for (int c = 0; c < 8; c++) s += longint'(wv[r*8+c]) * longint'(xv[c]);
    return out_word_t'(s);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (input_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b, required 0", input_ready);
    end
    total++;
    if (output_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b, required 0", output_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (input_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_ready: got %b, required 1", input_ready);
    end
    total++;
    if (output_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_valid: got %b, required 0", output_valid);
    end
  endtask

  task automatic test_before_matrix();
    out_word_t y;
    for (int i = 0; i < 8; i++) xv[i] = in_word_t'(i + 1);
    load_product(1'b0, 0);
    for (int r = 0; r < 8; r++) begin
      recv(y);
      total++;
      if (y !== 28'sd0) begin
        bad++; $display("FAIL zero_w row%0d: got %0d, required 0", r, y);
      end
    end
  endtask

  task automatic test_identity();
    out_word_t y;
    logic signed [13:0] xs [8];
    xs = '{14'sd1, -14'sd2, 14'sd3, -14'sd4, 14'sd5, -14'sd6, 14'sd7, -14'sd8};
    for (int i = 0; i < 64; i++) wv[i] = (i / 8 == i % 8) ? 14'sd1 : 14'sd0;
    for (int i = 0; i < 8; i++) xv[i] = xs[i];
    for (int i = 0; i < 64; i++) send(wv[i], 1'b1, 0);
    total++;
    if (output_valid !== 1'b0) begin
      bad++; $display("FAIL valid_during_load: got %b, required 0", output_valid);
    end
    for (int i = 0; i < 8; i++) send(xv[i], 1'b1, 0);
    total++;
    if (output_valid !== 1'b1) begin
      bad++; $display("FAIL latency: output_valid got %b, required 1", output_valid);
    end
    total++;
    if (input_ready !== 1'b0) begin
      bad++; $display("FAIL ready_in_out: got %b, required 0", input_ready);
    end
    for (int r = 0; r < 8; r++) begin
      recv(y);
      total++;
      if (y !== out_word_t'(xs[r])) begin
        bad++; $display("FAIL identity row%0d: got %0d, required %0d", r, y, xs[r]);
      end
    end
    @(negedge clk);
    total++;
    if (input_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_out: got %b, required 1", input_ready);
    end
  endtask

  task automatic test_reuse();
    out_word_t y;
    for (int i = 0; i < 8; i++) xv[i] = in_word_t'(10 + i);
    load_product(1'b0, 1);
    for (int r = 0; r < 8; r++) begin
      recv(y);
      total++;
      if (y !== out_word_t'(10 + r)) begin
        bad++; $display("FAIL reuse row%0d: got %0d, required %0d", r, y, 10 + r);
      end
    end
  endtask

  task automatic test_extremes();
    out_word_t y;
    // (-8192)^2 * 8 = 2^29, which wraps to 0 in 28 bits.
    for (int i = 0; i < 64; i++) wv[i] = -14'sd8192;
    for (int i = 0; i < 8; i++) xv[i] = -14'sd8192;
    load_product(1'b1, 0);
    for (int r = 0; r < 8; r++) begin
      recv(y);
      total++;
      if (y !== 28'sd0) begin
        bad++; $display("FAIL wrap_neg row%0d: got %0d, required 0", r, y);
      end
    end
    // 8191 * -8192 * 8 = -536805376, plus 2*2^28 = 65536.
    for (int i = 0; i < 64; i++) wv[i] = 14'sd8191;
    load_product(1'b1, 0);
    for (int r = 0; r < 8; r++) begin
      recv(y);
      total++;
      if (y !== 28'sd65536) begin
        bad++; $display("FAIL wrap_mix row%0d: got %0d, required 65536", r, y);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    out_word_t y;
    int exp_r [8];
    exp_r = '{-168, -132, -96, -60, -24, 12, 48, 84};
    for (int i = 0; i < 30; i++) send(14'sd5, 1'b1, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (input_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_ready: got %b, required 0", input_ready);
    end
    total++;
    if (output_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_valid: got %b, required 0", output_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // W was cleared by reset, so a vector-only product yields zeros.
    test_before_matrix();
    // W[r][c] = r - c, x = 1..8  ->  y[r] = 36r - 168.
    for (int i = 0; i < 64; i++) wv[i] = in_word_t'(i / 8 - i % 8);
    for (int i = 0; i < 8; i++) xv[i] = in_word_t'(i + 1);
    load_product(1'b1, 0);
    for (int r = 0; r < 8; r++) begin
      recv(y);
      total++;
      if (y !== out_word_t'(exp_r[r])) begin
        bad++; $display("FAIL after_reset row%0d: got %0d, required %0d", r, y, exp_r[r]);
      end
    end
  endtask

  task automatic test_random();
    logic      nm;
    logic      got;
    logic      have_prev;
    out_word_t prev_d;
    int        g;
    for (int p = 0; p < 300; p++) begin
      nm = (p == 0) || ($urandom_range(0, 3) == 0);
      if (nm) begin
        for (int i = 0; i < 64; i++) wv[i] = in_word_t'($urandom);
      end
      for (int i = 0; i < 8; i++) xv[i] = in_word_t'($urandom);
      for (int r = 0; r < 8; r++) ev[r] = model_row(r);
      load_product(nm, 2);
      for (int r = 0; r < 8; r++) begin
        got = 1'b0;
        have_prev = 1'b0;
        g = 0;
        while (!got && g < 500) begin
          @(negedge clk);
          g++;
          if (have_prev && output_valid) begin
            total++;
            if (output_data !== prev_d) begin
              bad++; $display("FAIL stall_hold p%0d row%0d: got %0d, required %0d", p, r, output_data, prev_d);
            end
          end
          output_ready = ($urandom_range(0, 2) != 0);
          if (output_valid && output_ready) begin
            total++;
            if (output_data !== ev[r]) begin
              bad++; $display("FAIL random p%0d row%0d: got %0d, required %0d", p, r, output_data, ev[r]);
            end
            got = 1'b1;
          end else if (output_valid) begin
            prev_d = output_data;
            have_prev = 1'b1;
          end
        end
        if (!got) begin
          total++; bad++;
          $display("FAIL random_timeout p%0d row%0d: output_valid %b, required 1", p, r, output_valid);
        end
      end
      @(posedge clk);
      #1;
      output_ready = 1'b0;
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    input_valid  = 1'b0;
    input_data   = 'x;
    new_matrix   = 1'bx;
    output_ready = 1'b0;
    test_reset();
    test_before_matrix();
    test_identity();
    test_reuse();
    test_extremes();
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
